fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decoder.
- Holds the program counter and issues one word address per cycle to the instruction cache.
- Passes the returned instruction, or a NOP, to the decoder, together with the matching PC.
- Handles cache misses, decoder bubbles (stall/replay) and branch redirects from execute, with a small FSM and a retired-fetch counter.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- NOP_INSTR, 32'h0000_0013: instruction substituted when no valid instruction is delivered (addi x0,x0,0).
- FLUSH_CYCLES, 1: cycles spent in FLUSH after a redirect; legal range 1-7.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_h, input, 1: reset, synchronous, active-high.
- branch_taken_from_execute, input, 1: redirect request.
- branch_target_from_execute, input, 32: redirect target; bits [1:0] ignored.
- bubble_from_decoder, input, 1: decoder discarded this cycle's instruction; hold the PC.
- icache_valid, input, 1: icache_instr is valid for pc_to_icache this cycle (same-cycle read).
- icache_instr, input, 32: instruction word from the cache.
- pc_to_icache, output, 32: fetch address (= pc_reg).
- icache_req, output, 1: fetch request.
- instr_from_fetch, output, 32: instruction to the decoder; combinational.
- pc_from_fetch, output, 32: registered copy of the previous cycle's pc_reg. It is aligned with the decoder's one-cycle instruction register.
- fetch_count, output, 32: instructions delivered and accepted.

Behaviour:
- Reset (rst_h=1 at an edge) has highest priority and overrides everything, including mid-miss or mid-flush. It sets:
  - state=IDLE, pc_reg=RESET_PC, pc_from_fetch=RESET_PC;
  - fetch_count=0, flush counter=0.
- While rst_h is high or state=IDLE: icache_req=0 and instr_from_fetch=NOP_INSTR.
- pc_from_fetch <= pc_reg on every non-reset edge, regardless of state.
- States: IDLE, RUN, MISS, FLUSH.
- Priority within RUN/MISS: redirect > miss > bubble > advance.
- IDLE:
  - icache_req=0, instr_from_fetch=NOP_INSTR.
  - Always goes to RUN next cycle; pc_reg holds.
- RUN and MISS:
  - icache_req=1.
  - If branch_taken_from_execute=1:
    - instr_from_fetch=NOP_INSTR;
    - pc_reg <= {target[31:2],2'b00};
    - flush counter <= FLUSH_CYCLES-1; next state FLUSH.
  - Else if icache_valid=0: instr_from_fetch=NOP_INSTR, pc_reg holds, next state MISS.
  - Else instr_from_fetch=icache_instr, and:
    - if bubble_from_decoder=1: pc_reg holds (instruction replayed next cycle), next state RUN;
    - else pc_reg <= pc_reg+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), fetch_count <= fetch_count+1 (wraps), next state RUN.
- FLUSH:
  - icache_req=1, instr_from_fetch=NOP_INSTR, pc_reg holds.
  - A new redirect reloads pc_reg and the counter and stays in FLUSH.
  - Else if the counter is 0, go to RUN; otherwise decrement.
  - icache_valid and bubble are ignored.
- Redirect penalty with FLUSH_CYCLES=1: NOP on the redirect cycle plus 1 FLUSH cycle. The target instruction is delivered on the 3rd cycle.
- fetch_count never increments on NOP substitution, during a bubble, or on a redirect cycle.

Decomposition:
- fetch_pkg holds:
  - fetch_state_t enum (IDLE, RUN, MISS, FLUSH);
  - NOP_INSTR default;
  - PC_STEP=32'd4.
- One sub-module, fetch_next_pc: combinational next-PC/next-state mux implementing the priority above. The FSM, counters and registers stay in fetch_unit.

Test Plan:
- Reset then icache_valid=1 constant, bubble=0:
  - IDLE cycle shows icache_req=0 and NOP.
  - Then pc_to_icache=0,4,8,...
  - pc_from_fetch lags by one cycle.
  - fetch_count increments each RUN cycle.
- Miss: icache_valid=0 for 3 cycles at PC 0x10:
  - pc_to_icache stays 0x10 and outputs NOP for 3 cycles.
  - Valid returns: the instruction is delivered, then PC goes to 0x14.
  - fetch_count rises by exactly 1.
- Bubble held 2 cycles at PC 0x20:
  - The same instruction is presented 3 times.
  - PC advances to 0x24 only after bubble drops.
  - fetch_count +1 total.
- Redirect to 0x103 while in MISS:
  - NOP, pc_to_icache=0x100, one FLUSH NOP.
  - Then icache_instr@0x100 is delivered.
  - No fetch_count change until that delivery.
- Back-to-back redirects (0x200 then 0x300 during FLUSH):
  - Stays in FLUSH.
  - Final fetch begins at 0x300; 0x200 is never delivered.
- Reset asserted mid-FLUSH and at PC 0xFFFF_FFFC:
  - Next edge gives IDLE, PC=RESET_PC, count=0.
  - Separately, wrap from 0xFFFF_FFFC to 0x0 is verified.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    MISS  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_if.sv
// Bus between the fetch stage and its neighbours: execute, decoder and icache.
interface fetch_if;

  logic        branch_taken_from_execute;
  logic [31:0] branch_target_from_execute;
  logic        bubble_from_decoder;
  logic        icache_valid;
  logic [31:0] icache_instr;
  logic [31:0] pc_to_icache;
  logic        icache_req;
  logic [31:0] instr_from_fetch;
  logic [31:0] pc_from_fetch;
  logic [31:0] fetch_count;

  // Fetch-stage side.
  modport master (
    input  branch_taken_from_execute,
    input  branch_target_from_execute,
    input  bubble_from_decoder,
    input  icache_valid,
    input  icache_instr,
    output pc_to_icache,
    output icache_req,
    output instr_from_fetch,
    output pc_from_fetch,
    output fetch_count
  );

  // Environment side (execute, decoder, icache).
  modport slave (
    output branch_taken_from_execute,
    output branch_target_from_execute,
    output bubble_from_decoder,
    output icache_valid,
    output icache_instr,
    input  pc_to_icache,
    input  icache_req,
    input  instr_from_fetch,
    input  pc_from_fetch,
    input  fetch_count
  );

endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC / next-state selection: redirect > miss > bubble > advance.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_WORD     = NOP_INSTR,
  parameter int          FLUSH_CYCLES = 1
) (
  input  fetch_state_t state,
  input  logic [31:0]  pc_reg,
  input  logic [2:0]   flush_cnt,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  input  logic         icache_valid,
  input  logic [31:0]  icache_instr,
  input  logic         bubble,
  output fetch_state_t next_state,
  output logic [31:0]  next_pc,
  output logic [2:0]   next_flush_cnt,
  output logic         count_en,
  output logic         req,
  output logic [31:0]  instr
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  // Select the next control state, PC, and the word handed to the decoder.
  always_comb begin
    next_state     = state;
    next_pc        = pc_reg;
    next_flush_cnt = flush_cnt;
    count_en       = 1'b0;
    req            = 1'b0;
    instr          = NOP_WORD;
    case (state)
      IDLE: begin
        next_state = RUN;
      end
      RUN, MISS: begin
        req = 1'b1;
        if (branch_taken) begin
          next_pc        = {branch_target[31:2], 2'b00};
          next_flush_cnt = FLUSH_LOAD;
          next_state     = FLUSH;
        end else if (!icache_valid) begin
          next_state = MISS;
        end else begin
          instr      = icache_instr;
          next_state = RUN;
          // A bubble replays the same word next cycle, so the PC holds.
          if (!bubble) begin
            next_pc  = pc_reg + PC_STEP;
            count_en = 1'b1;
          end
        end
      end
      FLUSH: begin
        req = 1'b1;
        if (branch_taken) begin
          next_pc        = {branch_target[31:2], 2'b00};
          next_flush_cnt = FLUSH_LOAD;
        end else if (flush_cnt == 3'd0) begin
          next_state = RUN;
        end else begin
          next_flush_cnt = flush_cnt - 3'd1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, fetch FSM, PC pipeline copy and retired-fetch counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD     = NOP_INSTR,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic   clk,
  input  logic   rst_h,
  fetch_if.master bus
);

  fetch_state_t state, next_state;
  logic [31:0]  pc_reg, next_pc;
  logic [31:0]  pc_p1;
  logic [31:0]  fetch_count;
  logic [2:0]   flush_cnt, next_flush_cnt;
  logic         count_en;
  logic         req;
  logic [31:0]  instr;

  fetch_next_pc #(
    .NOP_WORD     (NOP_WORD),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) u_next_pc (
    .state          (state),
    .pc_reg         (pc_reg),
    .flush_cnt      (flush_cnt),
    .branch_taken   (bus.branch_taken_from_execute),
    .branch_target  (bus.branch_target_from_execute),
    .icache_valid   (bus.icache_valid),
    .icache_instr   (bus.icache_instr),
    .bubble         (bus.bubble_from_decoder),
    .next_state     (next_state),
    .next_pc        (next_pc),
    .next_flush_cnt (next_flush_cnt),
    .count_en       (count_en),
    .req            (req),
    .instr          (instr)
  );

  // FSM state, PC and flush counter; reset wins over any in-flight miss or flush.
  always_ff @(posedge clk) begin
    if (rst_h) begin
      state     <= IDLE;
      pc_reg    <= RESET_PC;
      flush_cnt <= 3'd0;
    end else begin
      state     <= next_state;
      pc_reg    <= next_pc;
      flush_cnt <= next_flush_cnt;
    end
  end

  // Stage p1: PC copy aligned with the decoder's instruction register.
  always_ff @(posedge clk) begin
    if (rst_h) begin
      pc_p1 <= RESET_PC;
    end else begin
      pc_p1 <= pc_reg;
    end
  end

  // Count instructions the decoder actually accepted.
  always_ff @(posedge clk) begin
    if (rst_h) begin
      fetch_count <= 32'd0;
    end else if (count_en) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign bus.pc_to_icache     = pc_reg;
  assign bus.icache_req       = req & ~rst_h;
  assign bus.instr_from_fetch = rst_h ? NOP_WORD : instr;
  assign bus.pc_from_fetch    = pc_p1;
  assign bus.fetch_count      = fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, miss, bubble, redirects, wrap and reset.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_h;
  int   n_checks;
  int   n_errors;

  fetch_if bus ();

  fetch_unit #(
    .RESET_PC     (32'h0000_0000),
    .NOP_WORD     (NOP),
    .FLUSH_CYCLES (1)
  ) dut (
    .clk   (clk),
    .rst_h (rst_h),
    .bus   (bus)
  );

  // Icache model: word at address A reads as 32'hA500_0000 | A.
  assign bus.icache_instr = 32'hA500_0000 | bus.pc_to_icache;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_h = 1'b1;
    bus.branch_taken_from_execute  = 1'b0;
    bus.branch_target_from_execute = 32'h0;
    bus.bubble_from_decoder        = 1'b0;
    bus.icache_valid               = 1'b1;

    // Reset state
    cycle();
    chk_eq("rst_req",   {31'd0, bus.icache_req}, 32'd0);
    chk_eq("rst_instr", bus.instr_from_fetch, NOP);
    chk_eq("rst_pc",    bus.pc_to_icache, 32'h0);
    chk_eq("rst_pcf",   bus.pc_from_fetch, 32'h0);
    chk_eq("rst_cnt",   bus.fetch_count, 32'd0);

    // IDLE cycle
    rst_h = 1'b0;
    settle();
    chk_eq("idle_req",   {31'd0, bus.icache_req}, 32'd0);
    chk_eq("idle_instr", bus.instr_from_fetch, NOP);
    cycle();

    // Sequential fetch 0,4,8,C
    for (int i = 0; i < 4; i++) begin
      settle();
      chk_eq("seq_req",   {31'd0, bus.icache_req}, 32'd1);
      chk_eq("seq_pc",    bus.pc_to_icache, 32'(4 * i));
      chk_eq("seq_pcf",   bus.pc_from_fetch, (i == 0) ? 32'h0 : 32'(4 * (i - 1)));
      chk_eq("seq_cnt",   bus.fetch_count, 32'(i));
      chk_eq("seq_instr", bus.instr_from_fetch, 32'hA500_0000 | 32'(4 * i));
      cycle();
    end

    // Miss for 3 cycles at 0x10
    bus.icache_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_eq("miss_pc",    bus.pc_to_icache, 32'h10);
      chk_eq("miss_instr", bus.instr_from_fetch, NOP);
      cycle();
    end
    chk_eq("miss_cnt", bus.fetch_count, 32'd4);
    bus.icache_valid = 1'b1;
    settle();
    chk_eq("miss_ret_instr", bus.instr_from_fetch, 32'hA500_0010);
    cycle();
    chk_eq("miss_next_pc", bus.pc_to_icache, 32'h14);
    chk_eq("miss_next_cnt", bus.fetch_count, 32'd5);
    cycle();
    cycle();
    cycle();

    // Bubble held 2 cycles at 0x20
    chk_eq("bub_pc0", bus.pc_to_icache, 32'h20);
    chk_eq("bub_cnt0", bus.fetch_count, 32'd8);
    bus.bubble_from_decoder = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk_eq("bub_pc",    bus.pc_to_icache, 32'h20);
      chk_eq("bub_instr", bus.instr_from_fetch, 32'hA500_0020);
      cycle();
    end
    bus.bubble_from_decoder = 1'b0;
    settle();
    chk_eq("bub_last_instr", bus.instr_from_fetch, 32'hA500_0020);
    cycle();
    chk_eq("bub_next_pc", bus.pc_to_icache, 32'h24);
    chk_eq("bub_next_cnt", bus.fetch_count, 32'd9);

    // Redirect to 0x103 while in MISS
    bus.icache_valid = 1'b0;
    settle();
    chk_eq("rdm_miss_instr", bus.instr_from_fetch, NOP);
    cycle();
    bus.branch_taken_from_execute  = 1'b1;
    bus.branch_target_from_execute = 32'h103;
    settle();
    chk_eq("rdm_br_instr", bus.instr_from_fetch, NOP);
    chk_eq("rdm_br_req", {31'd0, bus.icache_req}, 32'd1);
    cycle();
    bus.branch_taken_from_execute = 1'b0;
    bus.icache_valid = 1'b1;
    settle();
    chk_eq("rdm_fl_pc",    bus.pc_to_icache, 32'h100);
    chk_eq("rdm_fl_instr", bus.instr_from_fetch, NOP);
    chk_eq("rdm_fl_cnt",   bus.fetch_count, 32'd9);
    cycle();
    chk_eq("rdm_tgt_instr", bus.instr_from_fetch, 32'hA500_0100);
    chk_eq("rdm_tgt_cnt",   bus.fetch_count, 32'd9);
    cycle();
    chk_eq("rdm_after_pc",  bus.pc_to_icache, 32'h104);
    chk_eq("rdm_after_cnt", bus.fetch_count, 32'd10);

    // Back-to-back redirects 0x200 then 0x300
    bus.branch_taken_from_execute  = 1'b1;
    bus.branch_target_from_execute = 32'h200;
    settle();
    chk_eq("b2b_br1_instr", bus.instr_from_fetch, NOP);
    cycle();
    bus.branch_target_from_execute = 32'h300;
    settle();
    chk_eq("b2b_fl1_pc",    bus.pc_to_icache, 32'h200);
    chk_eq("b2b_fl1_instr", bus.instr_from_fetch, NOP);
    cycle();
    bus.branch_taken_from_execute = 1'b0;
    settle();
    chk_eq("b2b_fl2_pc",    bus.pc_to_icache, 32'h300);
    chk_eq("b2b_fl2_instr", bus.instr_from_fetch, NOP);
    cycle();
    chk_eq("b2b_tgt_pc",    bus.pc_to_icache, 32'h300);
    chk_eq("b2b_tgt_instr", bus.instr_from_fetch, 32'hA500_0300);
    chk_eq("b2b_tgt_cnt",   bus.fetch_count, 32'd10);
    cycle();
    chk_eq("b2b_after_cnt", bus.fetch_count, 32'd11);

    // Wrap from 0xFFFF_FFFC to 0
    bus.branch_taken_from_execute  = 1'b1;
    bus.branch_target_from_execute = 32'hFFFF_FFFF;
    cycle();
    bus.branch_taken_from_execute = 1'b0;
    cycle();
    chk_eq("wrap_pc",    bus.pc_to_icache, 32'hFFFF_FFFC);
    chk_eq("wrap_instr", bus.instr_from_fetch, 32'hFFFF_FFFC);
    cycle();
    chk_eq("wrap_next_pc",  bus.pc_to_icache, 32'h0);
    chk_eq("wrap_next_pcf", bus.pc_from_fetch, 32'hFFFF_FFFC);
    chk_eq("wrap_next_cnt", bus.fetch_count, 32'd12);

    // Reset mid-FLUSH at PC 0xFFFF_FFFC
    bus.branch_taken_from_execute  = 1'b1;
    bus.branch_target_from_execute = 32'hFFFF_FFFC;
    cycle();
    bus.branch_taken_from_execute = 1'b0;
    chk_eq("rfl_pc", bus.pc_to_icache, 32'hFFFF_FFFC);
    rst_h = 1'b1;
    settle();
    chk_eq("rfl_req_in_rst",   {31'd0, bus.icache_req}, 32'd0);
    chk_eq("rfl_instr_in_rst", bus.instr_from_fetch, NOP);
    cycle();
    chk_eq("rfl_pc_after", bus.pc_to_icache, 32'h0);
    chk_eq("rfl_pcf_after", bus.pc_from_fetch, 32'h0);
    chk_eq("rfl_cnt_after", bus.fetch_count, 32'd0);
    rst_h = 1'b0;
    settle();
    chk_eq("rfl_idle_req",   {31'd0, bus.icache_req}, 32'd0);
    chk_eq("rfl_idle_instr", bus.instr_from_fetch, NOP);
    cycle();
    chk_eq("rfl_run_instr", bus.instr_from_fetch, 32'hA500_0000);
    chk_eq("rfl_run_req",   {31'd0, bus.icache_req}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
